// File: rtl/rv_core_pkg.sv
// Shared rv32i core definitions: address width, the bubble instruction and
// the fetch FSM encoding.
package rv_core_pkg;

    localparam int XLEN_ADDR = 16;

    // addi x0,x0,0 - used for bubbles and out-of-range fetches
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    // Force a byte address onto a word boundary
    function automatic logic [XLEN_ADDR-1:0] word_align(input logic [XLEN_ADDR-1:0] a);
        return {a[XLEN_ADDR-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: priority mux of control targets
// (trap > ret > redirect), word-alignment fix-up and misalign detection.
// The sequential pc+4 value is also produced here so that all next-PC
// arithmetic sits in one place.
module pc_next_sel
    import rv_core_pkg::*;
(
    input  logic [XLEN_ADDR-1:0] pc,
    input  logic                 trap_req,
    input  logic [XLEN_ADDR-1:0] trap_vec,
    input  logic                 ret_req,
    input  logic [XLEN_ADDR-1:0] ret_pc,
    input  logic                 redirect_valid,
    input  logic [XLEN_ADDR-1:0] redirect_pc,
    output logic                 ctrl_event,
    output logic [XLEN_ADDR-1:0] ctrl_target,
    output logic                 ctrl_misalign,
    output logic [XLEN_ADDR-1:0] pc_seq
);

    logic [XLEN_ADDR-1:0] raw_target;

    // Pick the highest-priority control target; a raw target is only meaningful when ctrl_event is set
    always_comb begin
        raw_target = redirect_pc;
        ctrl_event = trap_req | ret_req | redirect_valid;
        if (trap_req)
            raw_target = trap_vec;
        else if (ret_req)
            raw_target = ret_pc;
    end

    // Low address bits are dropped rather than faulted; the flag lets the core log it
    assign ctrl_target   = word_align(raw_target);
    assign ctrl_misalign = ctrl_event && (raw_target[1:0] != 2'b00);

    // Natural 16-bit wrap: 0xFFFC + 4 -> 0x0000
    assign pc_seq = pc + XLEN_ADDR'(4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the returned word into the IF/ID register. Control events
// (trap/ret/redirect) flush the IF/ID slot and retarget the PC in any state;
// halt stops new fetches while letting the live slot drain to decode.
module fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] im_addr,
    input  logic [31:0] im_rd,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        trap_req,
    input  logic [15:0] trap_vec,
    input  logic        ret_req,
    input  logic [15:0] ret_pc,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_fault,
    output logic [15:0] trap_epc,
    output logic        misalign
);

    // One bit wider than the address so 4*IM_DEPTH = 64K still compares correctly
    localparam logic [XLEN_ADDR:0] IM_BYTES = (XLEN_ADDR+1)'(4 * IM_DEPTH);

    fetch_state_e         state;
    logic [XLEN_ADDR-1:0] pc;

    logic                 ctrl_event;
    logic [XLEN_ADDR-1:0] ctrl_target;
    logic                 ctrl_misalign;
    logic [XLEN_ADDR-1:0] pc_seq;
    logic                 out_of_range;
    logic                 slot_free;

    pc_next_sel u_pc_next_sel (
        .pc             (pc),
        .trap_req       (trap_req),
        .trap_vec       (trap_vec),
        .ret_req        (ret_req),
        .ret_pc         (ret_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ctrl_event     (ctrl_event),
        .ctrl_target    (ctrl_target),
        .ctrl_misalign  (ctrl_misalign),
        .pc_seq         (pc_seq)
    );

    assign im_addr      = pc;
    assign out_of_range = ({1'b0, pc} >= IM_BYTES);
    // IF/ID slot can take a new word when empty or being consumed this cycle
    assign slot_free    = !id_valid || id_ready;

    // PC, IF/ID register and RUN/HALT FSM; control events override everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FS_RUN;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
            id_fault <= 1'b0;
            trap_epc <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (ctrl_event) begin
                // Flush and retarget; fetch from the new pc starts next cycle
                pc       <= ctrl_target;
                id_valid <= 1'b0;
                id_fault <= 1'b0;
                misalign <= ctrl_misalign;
                state    <= FS_RUN;
                if (trap_req)
                    trap_epc <= id_valid ? id_pc : pc;
            end else begin
                unique case (state)
                    FS_RUN: begin
                        if (halt_req) begin
                            // No fetch on the halting cycle; live slot may still drain
                            state <= FS_HALT;
                            if (id_valid && id_ready)
                                id_valid <= 1'b0;
                        end else if (slot_free) begin
                            id_valid <= 1'b1;
                            id_pc    <= pc;
                            id_instr <= out_of_range ? NOP_INSTR : im_rd;
                            id_fault <= out_of_range;
                            pc       <= pc_seq;
                        end
                    end
                    FS_HALT: begin
                        // pc holds; leaving HALT does not fetch until the next cycle
                        if (resume)
                            state <= FS_RUN;
                        if (id_valid && id_ready)
                            id_valid <= 1'b0;
                    end
                    default: state <= FS_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small behavioural ROM feeds im_rd and
// every expectation is a hand-computed constant.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] im_addr;
    logic [31:0] im_rd;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        trap_req;
    logic [15:0] trap_vec;
    logic        ret_req;
    logic [15:0] ret_pc;
    logic        halt_req;
    logic        resume;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic        id_fault;
    logic [15:0] trap_epc;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [0:127];

    always #5 clk = ~clk;

    // Word 0..2 from the I/R test program, the rest tagged with their index
    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'h0A00_0000 | 32'(i);
        rom[0] = 32'h0030_0413;
        rom[1] = 32'h0010_0493;
        rom[2] = 32'h0100_0913;
    end

    // Out-of-range reads return garbage that the DUT must ignore
    assign im_rd = (im_addr < 16'h0200) ? rom[im_addr[8:2]] : 32'hDEAD_BEEF;

    fetch_unit #(.RESET_PC(16'h0000), .IM_DEPTH(128)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_rd          (im_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_req       (trap_req),
        .trap_vec       (trap_vec),
        .ret_req        (ret_req),
        .ret_pc         (ret_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_fault       (id_fault),
        .trap_epc       (trap_epc),
        .misalign       (misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full IF/ID slot in one call
    task automatic chk_id(input string tag, input logic v, input logic [15:0] pc,
                          input logic [31:0] ins, input logic flt);
        chk({tag, ".valid"}, 32'(id_valid), 32'(v));
        chk({tag, ".pc"},    32'(id_pc),    32'(pc));
        chk({tag, ".instr"}, id_instr,      ins);
        chk({tag, ".fault"}, 32'(id_fault), 32'(flt));
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 0; redirect_pc = 0; trap_req = 0; trap_vec = 0;
        ret_req = 0; ret_pc = 0; halt_req = 0; resume = 0; id_ready = 1;

        // --- reset state
        step(); step();
        chk_id("rst", 1'b0, 16'h0000, 32'h0000_0013, 1'b0);
        chk("rst.epc", 32'(trap_epc), 32'h0);
        chk("rst.mis", 32'(misalign), 32'h0);
        chk("rst.addr", 32'(im_addr), 32'h0);
        rst_n = 1'b1;

        // --- 1: sequential fetch
        step(); chk_id("seq0", 1'b1, 16'h0000, 32'h0030_0413, 1'b0);
        step(); chk_id("seq1", 1'b1, 16'h0004, 32'h0010_0493, 1'b0);
        step(); chk_id("seq2", 1'b1, 16'h0008, 32'h0100_0913, 1'b0);
        chk("seq2.addr", 32'(im_addr), 32'h000C);

        // --- 2: stall for 3 cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_id("stall", 1'b1, 16'h0008, 32'h0100_0913, 1'b0);
            chk("stall.addr", 32'(im_addr), 32'h000C);
        end
        id_ready = 1'b1;
        step(); chk_id("release", 1'b1, 16'h000C, 32'h0A00_0003, 1'b0);
        chk("release.addr", 32'(im_addr), 32'h0010);

        // --- 3: redirect while stalled, then trap beating redirect
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0014;
        step(); chk("redir.valid", 32'(id_valid), 32'h0);
        chk("redir.addr", 32'(im_addr), 32'h0014);
        redirect_valid = 1'b0; id_ready = 1'b1;
        step(); chk_id("redir.fetch", 1'b1, 16'h0014, 32'h0A00_0005, 1'b0);
        trap_req = 1'b1; trap_vec = 16'h0100; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step(); chk("trapwin.addr", 32'(im_addr), 32'h0100);
        chk("trapwin.valid", 32'(id_valid), 32'h0);
        chk("trapwin.epc", 32'(trap_epc), 32'h0014);
        trap_req = 1'b0; redirect_valid = 1'b0;
        step(); chk_id("trapwin.fetch", 1'b1, 16'h0100, 32'h0A00_0040, 1'b0);

        // --- 4: trap with live slot at 0x18, ret to 0x1C
        redirect_valid = 1'b1; redirect_pc = 16'h0018;
        step(); redirect_valid = 1'b0;
        step(); chk_id("pre_trap", 1'b1, 16'h0018, 32'h0A00_0006, 1'b0);
        trap_req = 1'b1; trap_vec = 16'h0100;
        step(); chk("trap.epc", 32'(trap_epc), 32'h0018);
        chk("trap.addr", 32'(im_addr), 32'h0100);
        trap_req = 1'b0;
        step(); chk_id("trap.fetch", 1'b1, 16'h0100, 32'h0A00_0040, 1'b0);
        ret_req = 1'b1; ret_pc = 16'h001C;
        step(); chk("ret.addr", 32'(im_addr), 32'h001C);
        chk("ret.valid", 32'(id_valid), 32'h0);
        ret_req = 1'b0;
        // trap with empty slot captures pc itself
        trap_req = 1'b1; trap_vec = 16'h0080;
        step(); chk("trap_empty.epc", 32'(trap_epc), 32'h001C);
        chk("trap_empty.addr", 32'(im_addr), 32'h0080);
        trap_req = 1'b0;
        // ret beats redirect
        ret_req = 1'b1; ret_pc = 16'h001C; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step(); chk("retwin.addr", 32'(im_addr), 32'h001C);
        ret_req = 1'b0; redirect_valid = 1'b0;
        step(); chk_id("ret.fetch", 1'b1, 16'h001C, 32'h0A00_0007, 1'b0);

        // --- 5: misaligned target and out-of-range / wrap
        redirect_valid = 1'b1; redirect_pc = 16'h0016;
        step(); chk("mis.pulse", 32'(misalign), 32'h1);
        chk("mis.addr", 32'(im_addr), 32'h0014);
        redirect_valid = 1'b0;
        step(); chk("mis.clear", 32'(misalign), 32'h0);
        chk_id("mis.fetch", 1'b1, 16'h0014, 32'h0A00_0005, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 16'h01FC;
        step(); chk("aligned.mis", 32'(misalign), 32'h0);
        redirect_valid = 1'b0;
        step(); chk_id("last_word", 1'b1, 16'h01FC, 32'h0A00_007F, 1'b0);
        step(); chk_id("oor", 1'b1, 16'h0200, 32'h0000_0013, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 16'h0008;
        step(); redirect_valid = 1'b0;
        step(); chk_id("oor.clear", 1'b1, 16'h0008, 32'h0100_0913, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
        step(); redirect_valid = 1'b0;
        step(); chk_id("wrap.top", 1'b1, 16'hFFFC, 32'h0000_0013, 1'b1);
        chk("wrap.addr", 32'(im_addr), 32'h0000);
        step(); chk_id("wrap.zero", 1'b1, 16'h0000, 32'h0030_0413, 1'b0);

        // --- 6: halt with stalled slot, drain, resume
        halt_req = 1'b1; id_ready = 1'b0;
        step(); chk_id("halt.hold", 1'b1, 16'h0000, 32'h0030_0413, 1'b0);
        chk("halt.addr", 32'(im_addr), 32'h0004);
        id_ready = 1'b1;
        step(); chk("halt.drain", 32'(id_valid), 32'h0);
        step(); chk("halt.idle", 32'(id_valid), 32'h0);
        chk("halt.pc", 32'(im_addr), 32'h0004);
        halt_req = 1'b0; resume = 1'b1;
        step(); chk("resume.valid", 32'(id_valid), 32'h0);
        resume = 1'b0;
        step(); chk_id("resume.fetch", 1'b1, 16'h0004, 32'h0010_0493, 1'b0);
        // halt and resume together in RUN: halt wins
        halt_req = 1'b1; resume = 1'b1;
        step(); chk("halt_resume.valid", 32'(id_valid), 32'h0);
        halt_req = 1'b0; resume = 1'b0;
        step(); chk("halt_resume.idle", 32'(id_valid), 32'h0);
        chk("halt_resume.pc", 32'(im_addr), 32'h0008);
        // async reset during HALT
        #2 rst_n = 1'b0;
        #1 chk("rst_halt.addr", 32'(im_addr), 32'h0000);
        chk_id("rst_halt", 1'b0, 16'h0000, 32'h0000_0013, 1'b0);
        rst_n = 1'b1;
        step(); chk_id("rst_halt.run", 1'b1, 16'h0000, 32'h0030_0413, 1'b0);
        step(); chk_id("rst_halt.run2", 1'b1, 16'h0004, 32'h0010_0493, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
